// File: rtl/bus_pkg.sv
// bus_pkg: peripheral map and tracker state encoding shared by the bus read tracker
package bus_pkg;

    localparam int PERIPH_COUNT = 11;

    // Address nibble values from this bound upwards select no peripheral.
    localparam logic [3:0] UNMAPPED_IDX = 4'd11;

    typedef enum logic [3:0] {
        PERIPH_RAM         = 4'd0,
        PERIPH_IO          = 4'd1,
        PERIPH_UART        = 4'd2,
        PERIPH_RANDOM      = 4'd3,
        PERIPH_TIMER       = 4'd4,
        PERIPH_SDRAM       = 4'd5,
        PERIPH_SEQUENCER   = 4'd6,
        PERIPH_SAMPLE      = 4'd7,
        PERIPH_DAC_SPI     = 4'd8,
        PERIPH_SOUND       = 4'd9,
        PERIPH_SDCARD_SPI  = 4'd10
    } periph_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        ERR       = 2'd2
    } state_e;

    // One-hot select for a peripheral index; unmapped indices give an empty select.
    function automatic logic [PERIPH_COUNT-1:0] onehot(input logic [3:0] idx);
        return (idx < UNMAPPED_IDX) ? (PERIPH_COUNT'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: maps address[19:16] to a one-hot peripheral select and a mapped flag
module bus_addr_decode
    import bus_pkg::*;
(
    input  logic [31:0]             address_i,
    output logic [PERIPH_COUNT-1:0] sel_o,
    output logic                    mapped_o
);

    logic unused_addr;

    assign unused_addr = ^{address_i[31:20], address_i[15:0]};

    // Only the peripheral nibble matters; the rest of the address belongs to the peripheral.
    always_comb begin
        mapped_o = address_i[19:16] < UNMAPPED_IDX;
        sel_o    = onehot(address_i[19:16]);
    end

endmodule

// File: rtl/bus_read_tracker.sv
// bus_read_tracker: decodes CPU requests, issues peripheral strobes and times out reads
module bus_read_tracker
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readReq,
    input  logic        writeReq,
    input  logic [31:0] address,
    input  logic        readValid,
    output logic [10:0] periphSel,
    output logic        readEn,
    output logic        writeEn,
    output logic        stall,
    output logic        readDone,
    output logic        busError
);

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [PERIPH_COUNT-1:0] sel_q, sel_d, dec_sel;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    mapped, accept, bad;

    bus_addr_decode u_decode (
        .address_i (address),
        .sel_o     (dec_sel),
        .mapped_o  (mapped)
    );

    // In the cycle a read completes the CPU is still holding that read; it must not be taken again.
    assign accept = state_q == IDLE && !done_q && (readReq || writeReq);
    assign bad    = !mapped || (readReq && writeReq);
    assign stall  = state_q == READ_WAIT || (state_q == IDLE && readReq && !done_q);

    // State, wait counter and registered outputs; reset abandons any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and next outputs; strobes and select default to idle values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = '0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (readReq) begin
                        state_d = READ_WAIT;
                        sel_d   = dec_sel;
                        rd_en_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        sel_d   = dec_sel;
                        wr_en_d = 1'b1;
                    end
                end
            end
            READ_WAIT: begin
                if (readValid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    sel_d = sel_q;
                    cnt_d = cnt_q + {15'd0, cnt_q != 16'hFFFF};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign periphSel = sel_q;
    assign readEn    = rd_en_q;
    assign writeEn   = wr_en_q;
    assign readDone  = done_q;
    assign busError  = err_q;

endmodule
